demux1_4_stream: RTL and testbench
==================================

# demux1_4_stream

Registered 1-to-4 stream demultiplexer: the inverse of the team's 4:1 mux. Accepts one WIDTH-bit word per cycle on a valid/ready input, steers it by a 2-bit select to one of four output channels, and holds it there in a one-deep per-channel register until that channel's consumer takes it. It sits between a single producer and four independent consumers. Each channel also keeps a wrapping delivery counter for debug and verification.

## Interface
- WIDTH, 4, data width of the input word and of each output channel.
- CNT_W, 8, width of each per-channel delivery counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination channel: 0..3 selects out0..out3.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts the word this cycle.
- out0_data, out1_data, out2_data, out3_data  output  WIDTH each  registered channel data.
- out_valid  output  4  bit k means channel k holds a word.
- out_ready  input  4  bit k means consumer k takes the word this cycle.
- dlv_cnt  output  4*CNT_W  packed delivery counters; channel k occupies bits [k*CNT_W +: CNT_W].

## Operation
- Input handshake: acc = in_valid & in_ready. Output handshake k: dlv[k] = out_valid[k] & out_ready[k].
- in_ready = rst_n & (!out_valid[in_sel] | out_ready[in_sel]).
  - This is combinational from in_sel, out_valid and out_ready. There is no path from in_valid to in_ready.
  - Readiness depends only on the selected channel. A stalled channel never blocks words bound for other channels.
- On acc, channel k = in_sel updates on the next edge:
  - outk_data <= in_data.
  - out_valid[k] <= 1.
- Per channel k, each clock edge, in priority order:
  1. acc with in_sel==k: load (covers the simultaneous dlv[k] case; the new word replaces the delivered one and out_valid[k] stays 1).
  2. dlv[k]: out_valid[k] <= 0. outk_data keeps its last value.
  3. Otherwise: hold.
- While out_valid[k]=1 and out_ready[k]=0, outk_data and out_valid[k] are stable.
- Counters: on dlv[k], counter k increments by 1 modulo 2^CNT_W (255 wraps to 0 for CNT_W=8). Counters are never cleared except by reset.
- All four channels may deliver in the same cycle. At most one channel loads per cycle.
- in_sel and in_data are ignored when in_valid=0. Channel state is unchanged.

## Timing
- Reset (rst_n low, asynchronous assert), effective immediately:
  - out_valid=4'b0000.
  - out0..out3_data=0.
  - dlv_cnt=0.
  - in_ready=0 for as long as rst_n is low.
- Release is sampled synchronously. The first acceptance is possible in the first cycle with rst_n high.
- Latency: word accepted at edge N appears on outk_data with out_valid[k]=1 after edge N (visible in cycle N+1).
- Throughput:
  - One word per cycle when consumers keep out_ready high. This holds even for back-to-back words to the same channel, via same-cycle replace.
  - With a consumer stalled, its channel accepts exactly one word, then in_ready=0 for that in_sel.
- Reset mid-operation: any held words are discarded and counters clear. No output handshake is reported after reset asserts.
- The counter increments on the same edge that completes dlv[k].

## Test plan
- Reset then route: assert rst_n=0 with in_valid=1, then release. Require in_ready=0 and all outputs 0 during reset. Then send in_sel=0, 1, 2, 3 with data 4'b1010, 4'b1111, 4'b1100, 4'b1010, one per cycle, all out_ready=1. Require each word on the matching channel exactly one cycle after its acceptance, only that out_valid bit high, and dlv_cnt fields each 1.
- Back-pressure: hold out_ready[2]=0 and send 4'b1110 to channel 2. Require out2_data=4'b1110 held stable and in_ready=0 while in_sel=2. Then send in_sel=0 with 4'b1000. Require it accepted and delivered on out0 while channel 2 stays held.
- Same-cycle replace: channel 1 holds 4'b0010 with out_ready[1]=1 while 4'b0101 for channel 1 is offered. Require acceptance, out_valid[1] staying 1, out1_data=4'b0101 next cycle, and counter 1 +1.
- Simultaneous delivery: fill all four channels with out_ready=0, then raise out_ready=4'b1111 for one cycle. Require out_valid=4'b0000 next cycle and every counter +1.
- Counter wrap: deliver 256 words to channel 3. Require counter 3 to go 255 to 0 with other counters unchanged.
- Reset mid-stall: channel 2 is holding a word and rst_n pulses low between edges. Require out_valid and dlv_cnt to clear immediately, and normal routing afterwards.

Source files
------------

// File: rtl/demux1_4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one producer-side valid/ready
// input and four consumer-side channels with per-channel debug counters.
interface demux1_4_stream_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out0_data;
    logic [WIDTH-1:0]   out1_data;
    logic [WIDTH-1:0]   out2_data;
    logic [WIDTH-1:0]   out3_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*CNT_W-1:0] dlv_cnt;

    // Demultiplexer side: takes the input stream, drives the four channels.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out0_data, out1_data, out2_data, out3_data,
               out_valid, dlv_cnt
    );

    // Environment side: producer plus the four consumers.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out0_data, out1_data, out2_data, out3_data,
               out_valid, dlv_cnt
    );
endinterface

// File: rtl/demux1_4_stream.sv
// Registered 1-to-4 stream demultiplexer. Each accepted word is steered by
// in_sel into a one-deep holding register for that channel; each channel
// counts its completed deliveries (wrapping) for debug.
module demux1_4_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demux1_4_stream_if.slave   bus
);
    logic [3:0]         valid_q;
    logic [WIDTH-1:0]   data_q [4];
    logic [CNT_W-1:0]   cnt_q  [4];
    logic [3:0]         load;
    logic [3:0]         dlv;
    logic               ready;
    logic               acc;
    logic [4*CNT_W-1:0] cnt_flat;

    // Handshake decode: readiness looks only at the selected channel, so a
    // stalled consumer never blocks words bound for the other channels.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        ready = 1'b0;
        acc   = 1'b0;
        load  = '0;
        dlv   = '0;
        ready = rst_n & (~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel]);
        acc   = bus.in_valid & ready;
        for (int k = 0; k < 4; k++) begin
            load[k] = acc & (bus.in_sel == k[1:0]);
            dlv[k]  = valid_q[k] & bus.out_ready[k];
        end
    end

    // Channel registers and delivery counters; a load wins over a delivery,
    // which gives same-cycle replace when the consumer is taking the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                // NOTE: the data registers are reset too, because the channel outputs must read zero while in reset.
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // NOTE: non-blocking assignments so every channel samples this cycle's handshakes, not values updated earlier in the loop.
                if (load[k]) begin
                    data_q[k]  <= bus.in_data;
                    valid_q[k] <= 1'b1;
                end else if (dlv[k]) begin
                    valid_q[k] <= 1'b0;
                end
                if (dlv[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // Pack the four counters, channel k at bits [k*CNT_W +: CNT_W].
    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out0_data = data_q[0];
    assign bus.out1_data = data_q[1];
    assign bus.out2_data = data_q[2];
    assign bus.out3_data = data_q[3];
    assign bus.dlv_cnt   = cnt_flat;
endmodule

// File: tb/tb_demux1_4_stream.sv
// Directed bench for demux1_4_stream: reset, routing, back-pressure,
// same-cycle replace, simultaneous delivery, counter wrap, mid-stall reset.
module tb_demux1_4_stream;
    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    demux1_4_stream_if #(.WIDTH(4), .CNT_W(8)) bus ();

    demux1_4_stream #(.WIDTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [3:0] data);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // Reset with a word offered.
        rst_n         = 1'b0;
        bus.out_ready = 4'b1111;
        send(2'd0, 4'b1010);
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_cnt", bus.dlv_cnt, 32'h0);
        check("rst_data", 32'({bus.out3_data, bus.out2_data, bus.out1_data, bus.out0_data}), 32'h0);
        step();
        step();
        check("rst_hold_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_hold_valid", 32'(bus.out_valid), 32'h0);

        // Release and route one word to each channel.
        rst_n = 1'b1;
        #1;
        check("rt_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("rt0_valid", 32'(bus.out_valid), 32'b0001);
        check("rt0_data", 32'(bus.out0_data), 32'hA);
        send(2'd1, 4'b1111);
        step();
        check("rt1_valid", 32'(bus.out_valid), 32'b0010);
        check("rt1_data", 32'(bus.out1_data), 32'hF);
        send(2'd2, 4'b1100);
        step();
        check("rt2_valid", 32'(bus.out_valid), 32'b0100);
        check("rt2_data", 32'(bus.out2_data), 32'hC);
        send(2'd3, 4'b1010);
        step();
        check("rt3_valid", 32'(bus.out_valid), 32'b1000);
        check("rt3_data", 32'(bus.out3_data), 32'hA);
        bus.in_valid = 1'b0;
        step();
        check("rt_drain_valid", 32'(bus.out_valid), 32'h0);
        check("rt_cnt", bus.dlv_cnt, 32'h01010101);
        check("rt_data_kept", 32'(bus.out0_data), 32'hA);

        // Back-pressure on channel 2.
        bus.out_ready = 4'b1011;
        send(2'd2, 4'b1110);
        #1;
        check("bp_in_ready_free", 32'(bus.in_ready), 32'h1);
        step();
        check("bp_valid", 32'(bus.out_valid), 32'b0100);
        check("bp_data", 32'(bus.out2_data), 32'hE);
        check("bp_in_ready_stall", 32'(bus.in_ready), 32'h0);
        bus.in_data = 4'b0001;
        step();
        check("bp_data_stable", 32'(bus.out2_data), 32'hE);
        check("bp_valid_stable", 32'(bus.out_valid), 32'b0100);
        check("bp_in_ready_still", 32'(bus.in_ready), 32'h0);
        send(2'd0, 4'b1000);
        #1;
        check("bp_other_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("bp_other_valid", 32'(bus.out_valid), 32'b0101);
        check("bp_other_data", 32'(bus.out0_data), 32'h8);
        bus.in_valid = 1'b0;
        step();
        check("bp_other_dlv", 32'(bus.out_valid), 32'b0100);
        check("bp_held_data", 32'(bus.out2_data), 32'hE);
        check("bp_cnt", bus.dlv_cnt, 32'h01010102);
        bus.out_ready = 4'b1111;
        step();
        check("bp_release_valid", 32'(bus.out_valid), 32'h0);
        check("bp_release_cnt", bus.dlv_cnt, 32'h01020102);

        // Same-cycle replace on channel 1.
        bus.out_ready = 4'b1101;
        send(2'd1, 4'b0010);
        step();
        check("rep_first", 32'(bus.out1_data), 32'h2);
        bus.out_ready = 4'b1111;
        send(2'd1, 4'b0101);
        #1;
        check("rep_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("rep_valid", 32'(bus.out_valid), 32'b0010);
        check("rep_data", 32'(bus.out1_data), 32'h5);
        check("rep_cnt", bus.dlv_cnt, 32'h01020202);
        bus.in_valid = 1'b0;
        step();
        check("rep_drain_cnt", bus.dlv_cnt, 32'h01020302);

        // Fill all four, then deliver all at once.
        bus.out_ready = 4'b0000;
        send(2'd0, 4'h1);
        step();
        send(2'd1, 4'h2);
        step();
        send(2'd2, 4'h3);
        step();
        send(2'd3, 4'h4);
        step();
        check("sim_full_valid", 32'(bus.out_valid), 32'b1111);
        check("sim_full_data", 32'({bus.out3_data, bus.out2_data, bus.out1_data, bus.out0_data}), 32'h4321);
        check("sim_full_in_ready", 32'(bus.in_ready), 32'h0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        check("sim_valid", 32'(bus.out_valid), 32'h0);
        check("sim_cnt", bus.dlv_cnt, 32'h02030403);

        // Counter wrap on channel 3: 253 more deliveries reach 255, one more wraps.
        bus.out_ready = 4'b1000;
        for (int i = 0; i < 253; i++) begin
            send(2'd3, 4'(i));
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check("wrap_255", bus.dlv_cnt, 32'hFF030403);
        send(2'd3, 4'h7);
        step();
        bus.in_valid = 1'b0;
        step();
        check("wrap_0", bus.dlv_cnt, 32'h00030403);
        check("wrap_data", 32'(bus.out3_data), 32'h7);

        // Reset pulse between edges while channel 2 is stalled.
        bus.out_ready = 4'b1011;
        send(2'd2, 4'h9);
        step();
        bus.in_valid = 1'b0;
        check("mid_held", 32'(bus.out_valid), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(bus.out_valid), 32'h0);
        check("mid_cnt", bus.dlv_cnt, 32'h0);
        check("mid_data", 32'(bus.out2_data), 32'h0);
        check("mid_in_ready", 32'(bus.in_ready), 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        bus.out_ready = 4'b1111;
        send(2'd2, 4'h6);
        step();
        check("post_valid", 32'(bus.out_valid), 32'b0100);
        check("post_data", 32'(bus.out2_data), 32'h6);
        bus.in_valid = 1'b0;
        step();
        check("post_cnt", bus.dlv_cnt, 32'h00010000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
